// File: rtl/cic_iq_pkg.sv
// Shared types and helpers for the CIC I/Q pair packer.
// Holds the default component width, the packed pair layout and the saturation helper.
package cic_iq_pkg;

  localparam int DATA_W_DEFAULT = 16;

  // Working width for shifted components; covers DATA_W up to 41 with a 7-bit shift.
  localparam int SAT_W = 48;

  typedef enum logic {
    WAIT_I = 1'b0,
    WAIT_Q = 1'b1
  } pair_state_e;

  typedef struct packed {
    logic signed [DATA_W_DEFAULT-1:0] q;
    logic signed [DATA_W_DEFAULT-1:0] i;
  } iq_pair_t;

  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input int                      w
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = 1;
    hi  = (one <<< (w - 1)) - one;
    lo  = -hi - one;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/iq_pair_fifo.sv
// Synchronous FIFO with a registered head-of-queue output and full/empty flags.
// DEPTH must be a power of two, at least 2.
module iq_pair_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] dout_q, dout_d;
  logic         do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = dout_q;

  // The head register only moves on a pop or when a push lands in an empty queue.
  always_comb begin
    rd_d   = rd_q + (AW+1)'(do_pop);
    wr_d   = wr_q + (AW+1)'(do_push);
    dout_d = dout_q;
    if (do_push && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
      dout_d = din_i;
    end else if (do_pop && (rd_d != wr_q)) begin
      dout_d = mem_q[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      dout_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      dout_q <= dout_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/cic_iq_packer.sv
// Pairs interleaved I/Q beats from a CIC decimator, applies gain with saturation,
// and emits framed complex pairs on an AXI-Stream master through a small FIFO.
module cic_iq_packer
  import cic_iq_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  input  logic [LEN_W-1:0]    cfg_frame_len,
  input  logic [2:0]          cfg_gain_shift,
  output logic [2*DATA_W-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  input  logic                clr_status,
  output logic                overflow,
  output logic                sync_err
);

  localparam int FW = 2*DATA_W + 1;

  pair_state_e             state_q, state_d;
  logic [DATA_W-1:0]       held_i_q, held_i_d;
  logic                    stg_vld_q, stg_vld_d;
  logic [2*DATA_W-1:0]     stg_pair_q, stg_pair_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]        flen_q, flen_d;
  logic                    overflow_q, overflow_d;
  logic                    sync_err_q, sync_err_d;

  logic                    pair_fire, sync_set;
  logic signed [SAT_W-1:0] ext_i, ext_q;
  logic [DATA_W-1:0]       sat_i, sat_q;
  logic                    frame_last, pop, ovf_set, accepted;
  logic                    fifo_full, fifo_empty;
  logic [FW-1:0]           fifo_dout;

  always_comb begin
    state_d   = state_q;
    held_i_d  = held_i_q;
    pair_fire = 1'b0;
    sync_set  = 1'b0;
    if (s_axis_tvalid) begin
      case (state_q)
        WAIT_I: begin
          if (s_axis_tlast) begin
            sync_set = 1'b1;
          end else begin
            held_i_d = s_axis_tdata;
            state_d  = WAIT_Q;
          end
        end
        WAIT_Q: begin
          if (s_axis_tlast) begin
            pair_fire = 1'b1;
            state_d   = WAIT_I;
          end else begin
            sync_set = 1'b1;
            held_i_d = s_axis_tdata;
          end
        end
        default: state_d = WAIT_I;
      endcase
    end
  end

  assign ext_i = {{(SAT_W-DATA_W){held_i_q[DATA_W-1]}}, held_i_q};
  assign ext_q = {{(SAT_W-DATA_W){s_axis_tdata[DATA_W-1]}}, s_axis_tdata};
  assign sat_i = DATA_W'(saturate(ext_i <<< cfg_gain_shift, DATA_W));
  assign sat_q = DATA_W'(saturate(ext_q <<< cfg_gain_shift, DATA_W));

  assign stg_vld_d  = pair_fire;
  assign stg_pair_d = pair_fire ? {sat_q, sat_i} : stg_pair_q;

  assign pop        = m_axis_tvalid && m_axis_tready;
  assign ovf_set    = stg_vld_q && fifo_full && !pop;
  assign accepted   = stg_vld_q && !ovf_set;
  assign frame_last = (flen_q != '0) && (cnt_q == flen_q - LEN_W'(1));

  // A zero frame length parks the counter at 0 so a new length is picked up immediately.
  always_comb begin
    cnt_d = cnt_q;
    if (flen_q == '0) begin
      cnt_d = '0;
    end else if (accepted) begin
      cnt_d = frame_last ? '0 : cnt_q + LEN_W'(1);
    end
    flen_d     = (cnt_d == '0) ? cfg_frame_len : flen_q;
    overflow_d = ovf_set  || (overflow_q && !clr_status);
    sync_err_d = sync_set || (sync_err_q && !clr_status);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= WAIT_I;
      held_i_q   <= '0;
      stg_vld_q  <= 1'b0;
      stg_pair_q <= '0;
      cnt_q      <= '0;
      flen_q     <= cfg_frame_len;
      overflow_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_i_q   <= held_i_d;
      stg_vld_q  <= stg_vld_d;
      stg_pair_q <= stg_pair_d;
      cnt_q      <= cnt_d;
      flen_q     <= flen_d;
      overflow_q <= overflow_d;
      sync_err_q <= sync_err_d;
    end
  end

  iq_pair_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (stg_vld_q),
    .din_i   ({frame_last, stg_pair_q}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tlast  = fifo_dout[FW-1];
  assign m_axis_tdata  = fifo_dout[2*DATA_W-1:0];
  assign overflow      = overflow_q;
  assign sync_err      = sync_err_q;

endmodule
